mc_iformat_cpu: RTL
===================

# mc_iformat_cpu

Multi-cycle, parametrised successor to the single-cycle I-format CPU: one shared datapath sequenced by a state machine through FETCH/DECODE/EXEC/MEM/WB. The PC is internal and both memories sit behind req/ack handshakes, so wait-state memories are supported. Executes the R-type and I-format subset plus optional branches. Sits between the instruction memory and data memory models as the top-level core.

## Interface
- `XLEN`, 32: datapath/register width; legal 32..64.
- `NREG`, 32: register count; power of two, 2..32; register fields use low log2(NREG) bits.
- `RESET_PC`, 0: PC value after reset; must be a multiple of 4.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  instruction fetch request; held until ack.
- `imem_addr`  out  XLEN  fetch address (= PC).
- `imem_rdata`  in  32  instruction; valid when `imem_ack`=1.
- `imem_ack`  in  1  fetch complete.
- `dmem_req`  out  1  data access request; held until ack.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  XLEN  ALU result.
- `dmem_wdata`  out  XLEN  rt data.
- `dmem_rdata`  in  XLEN  load data; valid when `dmem_ack`=1.
- `dmem_ack`  in  1  data access complete.
- `pc_out`  out  XLEN  current PC.
- `halt`  out  1  core stopped on an illegal instruction.

## Operation
- Reset values: PC=`RESET_PC`, state FETCH, all req/we=0, `halt`=0, IR=0, registers=0.
- FETCH: `imem_req`=1, `imem_addr`=PC; on `imem_ack` latch IR, PC<=PC+4 (mod 2^XLEN) -> DECODE.
- DECODE: read rs/rt into A/B; decode opcode/funct; illegal -> HALT.
- EXEC: ALU on A and (B or zero-extended imm16); result latched in ALUOut. Branch: compare A/B, taken -> PC<=PC+(sext(imm16)<<2), -> FETCH. ALU ops -> WB; lw/sw -> MEM.
- MEM: `dmem_req`=1, `dmem_we`=1 for sw; on `dmem_ack`: sw -> FETCH, lw latches MDR -> WB.
- WB: write ALUOut (R/I) or MDR (lw) to rd (R-type) or rt (I-type) -> FETCH. Writes to r0 ignored; r0 reads 0.
- HALT: absorbing until reset; `halt`=1, no requests.
- R-type (op 0x00) funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02 (shamt). I-type op: addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B; all imm16 zero-extended to XLEN (unsigned convention kept). Arithmetic wraps mod 2^XLEN, no overflow trap.
- Any other opcode or funct is illegal.

## Timing
- Zero-wait memories: R/I ALU 4 cycles, lw 5, sw 4, branch 3.
- Each memory wait cycle adds one cycle; req, addr, we, wdata stable from assertion until the ack cycle; req drops the cycle after ack.
- ack sampled only while the matching req is high; stray acks ignored.
- `halt` asserts the cycle after DECODE of the illegal instruction.
- `rst_n` low mid-transaction: req deasserted asynchronously, pending access abandoned, restart at `RESET_PC`.

## Configuration
- `MC_CPU_BRANCH_EN` defined: beq (0x04) and bne (0x05) decoded and executed as above.
- Undefined: opcodes 0x04/0x05 are illegal -> HALT; comparator and branch adder not built.

## Structure
- `mc_cpu_pkg`: opcode and funct constants, state enum (FETCH, DECODE, EXEC, MEM, WB, HALT), ALU-op enum.
- Sub-module `mc_reg_file`: NREG×XLEN, 2 async read, 1 sync write, r0 hardwired zero, reset to 0 by `rst_n`.
- ALU and control stay inline in the top.

## Test plan
- Reset, zero-wait IM holding `addi $1,$0,5`; `addi $2,$0,7`; `add $3,$1,$2` -> $3=12, `pc_out`=12 after 12 cycles.
- `ori $1,$0,0x8000`; `sw $1,4($0)`; `lw $2,4($0)` with 3-wait DM -> DM[4]=0x8000, $2=0x8000, lw takes 8 cycles.
- `addi $0,$0,9` then `slt $4,$0,$0` -> r0 stays 0, $4=0; `sll $5,$1,4` with $1=1 -> $5=16.
- With `MC_CPU_BRANCH_EN`: $1=$2=3, `beq $1,$2,2` at PC 8 -> next fetch at 20; without macro -> `halt`=1, no further `imem_req`.
- Opcode 0x3F -> `halt`=1 persists 100 cycles; `rst_n` pulse during a waited `dmem_req` -> req low immediately, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared constants and types for the multi-cycle I-format CPU.
package mc_cpu_pkg;

    // Primary opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt,
        AluSll,
        AluSrl
    } alu_op_e;

endpackage

// File: rtl/mc_reg_file.sv
// Register file: NREG x XLEN, two asynchronous read ports, one synchronous
// write port, r0 reads as zero and ignores writes.
module mc_reg_file
    import mc_cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [XLEN-1:0]         wdata
);

    logic [XLEN-1:0] regs_q [NREG];

    // Clear everything on reset; write port skips r0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/mc_iformat_cpu.sv
// Multi-cycle I-format CPU core: FETCH/DECODE/EXEC/MEM/WB over one shared
// datapath, with req/ack handshakes to instruction and data memories.
// Optional feature macro: MC_CPU_BRANCH_EN enables beq/bne; without it those
// opcodes are illegal and the branch comparator/adder are not built.
module mc_iformat_cpu
    import mc_cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic [XLEN-1:0] pc_out,
    output logic            halt
);

    localparam int unsigned RW = $clog2(NREG);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q, b_q, alu_out_q, mdr_q;

    // Instruction fields
    logic [5:0]    opcode, funct;
    logic [4:0]    shamt;
    logic [15:0]   imm16;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign shamt  = ir_q[10:6];
    assign imm16  = ir_q[15:0];
    assign rs_idx = ir_q[21 +: RW];
    assign rt_idx = ir_q[16 +: RW];
    assign rd_idx = ir_q[11 +: RW];

    // Decoded control
    logic    illegal, use_imm, is_lw, is_sw, is_branch, dst_rd;
    alu_op_e alu_op;
`ifdef MC_CPU_BRANCH_EN
    logic    is_bne;
`endif

    // Register file interface
    logic [XLEN-1:0] rs_data, rt_data, rf_wdata;
    logic [RW-1:0]   rf_waddr;
    logic            rf_we;

    // ALU
    logic [XLEN-1:0] op_b, alu_res;
    logic            slt_bit;

    // IR stays stable from fetch ack onwards, so decode is purely combinational.
    always_comb begin
        illegal   = 1'b1;
        use_imm   = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_branch = 1'b0;
        dst_rd    = 1'b0;
        alu_op    = AluAdd;
`ifdef MC_CPU_BRANCH_EN
        is_bne    = 1'b0;
`endif
        case (opcode)
            OpRtype: begin
                dst_rd  = 1'b1;
                illegal = 1'b0;
                case (funct)
                    FnAdd:   alu_op = AluAdd;
                    FnSub:   alu_op = AluSub;
                    FnAnd:   alu_op = AluAnd;
                    FnOr:    alu_op = AluOr;
                    FnSlt:   alu_op = AluSlt;
                    FnSll:   alu_op = AluSll;
                    FnSrl:   alu_op = AluSrl;
                    default: illegal = 1'b1;
                endcase
            end
            OpAddi: begin
                illegal = 1'b0;
                use_imm = 1'b1;
                alu_op  = AluAdd;
            end
            OpAndi: begin
                illegal = 1'b0;
                use_imm = 1'b1;
                alu_op  = AluAnd;
            end
            OpOri: begin
                illegal = 1'b0;
                use_imm = 1'b1;
                alu_op  = AluOr;
            end
            OpLw: begin
                illegal = 1'b0;
                use_imm = 1'b1;
                is_lw   = 1'b1;
            end
            OpSw: begin
                illegal = 1'b0;
                use_imm = 1'b1;
                is_sw   = 1'b1;
            end
`ifdef MC_CPU_BRANCH_EN
            OpBeq: begin
                illegal   = 1'b0;
                is_branch = 1'b1;
            end
            OpBne: begin
                illegal   = 1'b0;
                is_branch = 1'b1;
                is_bne    = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    // Immediates are zero-extended for every I-type op, including lw/sw.
    assign op_b    = use_imm ? XLEN'(imm16) : b_q;
    assign slt_bit = $signed(a_q) < $signed(op_b);

    // ALU; shifts operate on rt with the shamt field.
    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            AluAdd:  alu_res = a_q + op_b;
            AluSub:  alu_res = a_q - op_b;
            AluAnd:  alu_res = a_q & op_b;
            AluOr:   alu_res = a_q | op_b;
            AluSlt:  alu_res = {{(XLEN-1){1'b0}}, slt_bit};
            AluSll:  alu_res = b_q << shamt;
            AluSrl:  alu_res = b_q >> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef MC_CPU_BRANCH_EN
    logic [XLEN-1:0] branch_target;
    logic            branch_taken;

    // pc_q already points past the branch when EXEC runs.
    assign branch_target = pc_q + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
    assign branch_taken  = is_branch && ((a_q == b_q) != is_bne);
`endif

    assign rf_we    = (state_q == StWb);
    assign rf_waddr = dst_rd ? rd_idx : rt_idx;
    assign rf_wdata = is_lw ? mdr_q : alu_out_q;

    mc_reg_file #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs_idx),
        .raddr2 (rt_idx),
        .rdata1 (rs_data),
        .rdata2 (rt_data),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    // State register; async reset also drops any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halt     = 1'b0;
        unique case (state_q)
            StFetch: begin
                // Gated so the request reads low while reset is held.
                imem_req = rst_n;
                if (imem_ack) state_d = StDecode;
            end
            StDecode: state_d = illegal ? StHalt : StExec;
            StExec: begin
                if (is_branch)           state_d = StFetch;
                else if (is_lw || is_sw) state_d = StMem;
                else                     state_d = StWb;
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) state_d = is_lw ? StWb : StFetch;
            end
            StWb:    state_d = StFetch;
            StHalt:  halt = 1'b1;
            default: state_d = StHalt;
        endcase
    end

    // Datapath registers, each loaded only in the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        ir_q <= imem_rdata;
                        pc_q <= pc_q + XLEN'(4);
                    end
                end
                StDecode: begin
                    a_q <= rs_data;
                    b_q <= rt_data;
                end
                StExec: begin
                    alu_out_q <= alu_res;
`ifdef MC_CPU_BRANCH_EN
                    if (branch_taken) pc_q <= branch_target;
`endif
                end
                StMem: begin
                    if (dmem_ack && is_lw) mdr_q <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = alu_out_q;
    assign dmem_wdata = b_q;
    assign pc_out     = pc_q;

endmodule
